// File: rtl/lcd_text_pkg.sv
// rtl/lcd_text_pkg.sv - shared constants, row addressing and state types for lcd_text_ctrl
package lcd_text_pkg;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] ENTRY     = 8'h06;
    localparam logic [7:0] SET_DDRAM = 8'h80;

    typedef enum logic [1:0] {
        RST_WAIT,
        INIT,
        ADDR,
        CHAR
    } ctrl_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EN,
        PH_HOLD,
        PH_WAIT
    } xfer_phase_t;

    // DDRAM start address of each panel row (rows 2/3 continue rows 0/1 on 4-line panels)
    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return CLEAR;
            default: return ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// rtl/lcd_bus_xfer.sv - one HD44780 bus transfer: setup, enable pulse, hold, then command wait
module lcd_bus_xfer
    import lcd_text_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CMD_WAIT   = 2000,
    parameter int CLEAR_WAIT = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmd_rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic       done_next,
    output logic       en,
    output logic       rs,
    output logic [7:0] db
);

    localparam int MAX_WAIT = (CMD_WAIT > CLEAR_WAIT) ? CMD_WAIT : CLEAR_WAIT;
    localparam int MAX_CNT  = (MAX_WAIT > CLK_DIV) ? MAX_WAIT : CLK_DIV;
    localparam int CW       = $clog2(MAX_CNT + 1);

    xfer_phase_t   phase, phase_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          long_q, long_n;
    logic          en_n, rs_n;
    logic [7:0]    db_n;
    logic          accept;

    assign busy = (phase != PH_IDLE);

    // A new start is taken in the last wait cycle so transfers run back to back.
    always_comb begin
        phase_n = phase;
        cnt_n   = cnt;
        long_n  = long_q;
        en_n    = en;
        rs_n    = rs;
        db_n    = db;
        accept  = start && ((phase == PH_IDLE) || done);
        if (accept) begin
            phase_n = PH_SETUP;
            cnt_n   = CW'(CLK_DIV - 1);
            long_n  = long_wait;
            en_n    = 1'b0;
            rs_n    = cmd_rs;
            db_n    = data;
        end else begin
            case (phase)
                PH_SETUP: begin
                    if (cnt == '0) begin
                        phase_n = PH_EN;
                        cnt_n   = CW'(CLK_DIV - 1);
                        en_n    = 1'b1;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                PH_EN: begin
                    if (cnt == '0) begin
                        phase_n = PH_HOLD;
                        cnt_n   = CW'(CLK_DIV - 1);
                        en_n    = 1'b0;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                PH_HOLD: begin
                    if (cnt == '0) begin
                        phase_n = PH_WAIT;
                        cnt_n   = long_q ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1);
                        rs_n    = 1'b0;
                        db_n    = 8'h00;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                PH_WAIT: begin
                    if (cnt == '0) begin
                        phase_n = PH_IDLE;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                default: phase_n = PH_IDLE;
            endcase
        end
        done_next = (phase_n == PH_WAIT) && (cnt_n == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= PH_IDLE;
            cnt    <= '0;
            long_q <= 1'b0;
            en     <= 1'b0;
            rs     <= 1'b0;
            db     <= 8'h00;
            done   <= 1'b0;
        end else begin
            phase  <= phase_n;
            cnt    <= cnt_n;
            long_q <= long_n;
            en     <= en_n;
            rs     <= rs_n;
            db     <= db_n;
            done   <= done_next;
        end
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780 8-bit text controller: init sequence then continuous buffer refresh
module lcd_text_ctrl
    import lcd_text_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int CLK_DIV    = 4,
    parameter int CMD_WAIT   = 2000,
    parameter int CLEAR_WAIT = 80000,
    parameter int INIT_WAIT  = 800000,
    localparam int DEPTH     = ROWS * COLS,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          init_done,
    output logic          frame_done,
    output logic          lcd_en,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic [7:0]    lcd_db,
    output logic          lcd_rst
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW  = $clog2(INIT_WAIT + 1);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    ctrl_state_t      state, state_n;
    logic [IW-1:0]    wait_cnt, wait_cnt_n;
    logic [1:0]       init_idx, init_idx_n;
    logic [RW-1:0]    row, row_n;
    logic [CLW-1:0]   col, col_n;
    logic             init_done_n, frame_done_n, lcd_rst_n;
    logic [7:0]       char_buf [DEPTH];
    logic [AW-1:0]    rd_addr;

    logic             xfer_start, xfer_rs, xfer_long, xfer_ready;
    logic [7:0]       xfer_data;
    logic             xfer_busy, xfer_done, xfer_done_next;

    assign lcd_rw = 1'b0;

    lcd_bus_xfer #(
        .CLK_DIV    (CLK_DIV),
        .CMD_WAIT   (CMD_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .start     (xfer_start),
        .cmd_rs    (xfer_rs),
        .data      (xfer_data),
        .long_wait (xfer_long),
        .busy      (xfer_busy),
        .done      (xfer_done),
        .done_next (xfer_done_next),
        .en        (lcd_en),
        .rs        (lcd_rs),
        .db        (lcd_db)
    );

    // state/row/col always describe the transfer currently on the bus
    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        init_idx_n  = init_idx;
        row_n       = row;
        col_n       = col;
        init_done_n = init_done;
        lcd_rst_n   = lcd_rst;
        xfer_start  = 1'b0;
        xfer_rs     = 1'b0;
        xfer_data   = 8'h00;
        xfer_long   = 1'b0;
        xfer_ready  = xfer_done || !xfer_busy;
        rd_addr     = '0;
        case (state)
            RST_WAIT: begin
                if (wait_cnt == IW'(INIT_WAIT - 1)) begin
                    state_n    = INIT;
                    lcd_rst_n  = 1'b0;
                    init_idx_n = 2'd0;
                    xfer_start = 1'b1;
                    xfer_data  = init_cmd(2'd0);
                end else begin
                    wait_cnt_n = wait_cnt + IW'(1);
                end
            end
            INIT: begin
                if (xfer_ready) begin
                    xfer_start = 1'b1;
                    if (init_idx == 2'd3) begin
                        state_n     = ADDR;
                        row_n       = '0;
                        init_done_n = 1'b1;
                        xfer_data   = SET_DDRAM | row_base(2'd0);
                    end else begin
                        init_idx_n = init_idx + 2'd1;
                        xfer_data  = init_cmd(init_idx_n);
                        xfer_long  = (xfer_data == CLEAR);
                    end
                end
            end
            ADDR: begin
                if (xfer_ready) begin
                    state_n    = CHAR;
                    col_n      = '0;
                    xfer_start = 1'b1;
                    xfer_rs    = 1'b1;
                end
            end
            CHAR: begin
                if (xfer_ready) begin
                    xfer_start = 1'b1;
                    if (col == CLW'(COLS - 1)) begin
                        col_n     = '0;
                        row_n     = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
                        state_n   = ADDR;
                        xfer_data = SET_DDRAM | row_base(2'(row_n));
                    end else begin
                        col_n   = col + CLW'(1);
                        xfer_rs = 1'b1;
                    end
                end
            end
            default: state_n = RST_WAIT;
        endcase
        if (xfer_rs) begin
            rd_addr   = AW'(int'(row_n) * COLS + int'(col_n));
            xfer_data = char_buf[rd_addr];
        end
    end

    assign frame_done_n = xfer_done_next && (state == CHAR)
                          && (row == RW'(ROWS - 1)) && (col == CLW'(COLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RST_WAIT;
            wait_cnt   <= '0;
            init_idx   <= 2'd0;
            row        <= '0;
            col        <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            lcd_rst    <= 1'b1;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            init_idx   <= init_idx_n;
            row        <= row_n;
            col        <= col_n;
            init_done  <= init_done_n;
            frame_done <= frame_done_n;
            lcd_rst    <= lcd_rst_n;
        end
    end

    // Same-cycle write and latch of one entry: the latch sees the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                char_buf[i] <= 8'h20;
            end
        end else if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
            char_buf[wr_addr] <= wr_data;
        end
    end

endmodule
